// File: rtl/flow_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flow_bus_pkg                                                             |
// | Shared definitions for the flow bus pipeline: skid-stage state encoding  |
// | and the width helper used to size the occupancy counter.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package flow_bus_pkg;

  // A stage holds at most two words: the main register and the skid register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // neither register valid
    ST_ONE   = 2'd1,  // main register valid
    ST_FULL  = 2'd2   // main and skid registers valid, upstream ready low
  } stage_state_e;

  // Ceiling log2, never less than 1 so a zero-depth build still has a
  // legal (constant zero) occupancy port.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flow_bus_pipeline_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flow_bus_pipeline_if                                                     |
// | Flow bus handshake bundle (valid / ready / data).                        |
// |   master : drives valid and data, receives ready                         |
// |   slave  : receives valid and data, drives ready                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface flow_bus_pipeline_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/flow_bus_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flow_bus_skid                                                            |
// | One two-entry skid stage. Main register drives the downstream side; the  |
// | skid register catches the word accepted while downstream stalls, so the  |
// | upstream ready can be a flop (!skid_valid) with no loss.                 |
// | Ports: clk, rst (async, active-low), enable (stall when USE_ENABLE=1),   |
// |        flush (only with FLOW_BUS_PIPELINE_FLUSH_EN), up_* / down_*       |
// |        handshake, occ_next (word count this stage holds after the edge). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flow_bus_skid
  import flow_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int USE_ENABLE = 0
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  enable,
`ifdef FLOW_BUS_PIPELINE_FLUSH_EN
  input  wire logic                  flush,
`endif
  input  wire logic                  up_valid,
  output logic                       up_ready,
  input  wire logic [DATA_WIDTH-1:0] up_data,
  output logic                       down_valid,
  input  wire logic                  down_ready,
  output logic [DATA_WIDTH-1:0]      down_data,
  output logic [1:0]                 occ_next
);

  stage_state_e          r_state;
  stage_state_e          w_state_next;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [DATA_WIDTH-1:0] r_s_data;
  logic                  w_active;
  logic                  w_flush;
  logic                  w_in;
  logic                  w_out;
  logic                  w_load_m;
  logic                  w_load_s;
  logic                  w_shift;

  assign w_active = (USE_ENABLE != 0) ? enable : 1'b1;
`ifdef FLOW_BUS_PIPELINE_FLUSH_EN
  assign w_flush  = flush;
`else
  assign w_flush  = 1'b0;
`endif

  assign w_in       = up_valid & r_ready & w_active;
  assign w_out      = (r_state != ST_EMPTY) & down_ready & w_active;
  assign up_ready   = r_ready & w_active;
  assign down_valid = (r_state != ST_EMPTY) & w_active;
  assign down_data  = r_m_data;

  always_comb begin
    w_state_next = r_state;
    w_load_m     = 1'b0;
    w_load_s     = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in) begin
          w_state_next = ST_ONE;
          w_load_m     = 1'b1;
        end
      end
      ST_ONE: begin
        case ({w_in, w_out})
          2'b10:   begin w_state_next = ST_FULL;  w_load_s = 1'b1; end
          2'b01:   begin w_state_next = ST_EMPTY; end
          2'b11:   begin w_load_m = 1'b1; end
          default: ;
        endcase
      end
      ST_FULL: begin
        // Ready is low here, so no new word can arrive this cycle.
        if (w_out) begin
          w_state_next = ST_ONE;
          w_shift      = 1'b1;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
    if (w_flush) begin
      w_state_next = ST_EMPTY;
      w_load_m     = 1'b0;
      w_load_s     = 1'b0;
      w_shift      = 1'b0;
    end
    case (w_state_next)
      ST_ONE:  occ_next = 2'd1;
      ST_FULL: occ_next = 2'd2;
      default: occ_next = 2'd0;
    endcase
  end

  // Ready is held while stalled so it stays low out of reset until the
  // first active edge, and resumes from its frozen value on enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b0;
    end else if (w_active || w_flush) begin
      r_state <= w_state_next;
      r_ready <= (w_state_next != ST_FULL);
    end
  end

  // Payload registers carry no reset.
  always_ff @(posedge clk) begin
    if (w_load_m)     r_m_data <= up_data;
    else if (w_shift) r_m_data <= r_s_data;
    if (w_load_s)     r_s_data <= up_data;
  end

endmodule
`default_nettype wire

// File: rtl/flow_bus_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flow_bus_pipeline                                                        |
// | Elastic, fully registered flow bus pipeline built from DEPTH skid        |
// | stages. Both the valid/data path and the ready path are cut by flops.    |
// | Ports: clk, rst (async, active-low), enable (stall when USE_ENABLE=1),   |
// |        flush (only with FLOW_BUS_PIPELINE_FLUSH_EN), up (slave side),    |
// |        down (master side), occupancy (registered word count).           |
// | DEPTH=0 builds a combinational pass-through.                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flow_bus_pipeline
  import flow_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2,
  parameter int USE_ENABLE = 0,
  parameter int CNT_WIDTH  = clog2(2 * DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             enable,
`ifdef FLOW_BUS_PIPELINE_FLUSH_EN
  input  wire logic             flush,
`endif
  flow_bus_pipeline_if.slave    up,
  flow_bus_pipeline_if.master   down,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  if (DEPTH == 0) begin : g_bypass
    logic w_active;
    assign w_active   = (USE_ENABLE != 0) ? enable : 1'b1;
    assign down.valid = up.valid & w_active;
    assign up.ready   = down.ready & w_active;
    assign down.data  = up.data;
    assign occupancy  = '0;
  end else begin : g_pipe
    // Chain index i is the upstream side of stage i; index DEPTH is the output.
    logic [DEPTH:0]        w_valid;
    logic [DEPTH:0]        w_ready;
    logic [DATA_WIDTH-1:0] w_data [DEPTH+1];
    logic [1:0]            w_occ  [DEPTH];
    logic [CNT_WIDTH-1:0]  w_occ_sum;
    logic [CNT_WIDTH-1:0]  r_occupancy;

    assign w_valid[0]     = up.valid;
    assign w_data[0]      = up.data;
    assign up.ready       = w_ready[0];
    assign down.valid     = w_valid[DEPTH];
    assign down.data      = w_data[DEPTH];
    assign w_ready[DEPTH] = down.ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      flow_bus_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .USE_ENABLE (USE_ENABLE)
      ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
`ifdef FLOW_BUS_PIPELINE_FLUSH_EN
        .flush      (flush),
`endif
        .up_valid   (w_valid[i]),
        .up_ready   (w_ready[i]),
        .up_data    (w_data[i]),
        .down_valid (w_valid[i+1]),
        .down_ready (w_ready[i+1]),
        .down_data  (w_data[i+1]),
        .occ_next   (w_occ[i])
      );
    end

    // Summing the stages' next counts keeps occupancy registered and in
    // step with the valid bits.
    always_comb begin
      w_occ_sum = '0;
      for (int i = 0; i < DEPTH; i++) begin
        w_occ_sum = w_occ_sum + CNT_WIDTH'(w_occ[i]);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_occupancy <= '0;
      else      r_occupancy <= w_occ_sum;
    end

    assign occupancy = r_occupancy;
  end

endmodule
`default_nettype wire

// File: tb/tb_flow_bus_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flow_bus_pipeline                                                     |
// | Self-checking bench: dut_a is DEPTH=2 with enable honoured, dut_b is     |
// | DEPTH=3 without. Directed vector table plus streaming, backpressure,     |
// | stall, random and (when FLOW_BUS_PIPELINE_FLUSH_EN) flush sequences.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_flow_bus_pipeline;

  logic clk;
  logic rst;
  logic enable_a;
  logic enable_b;
  logic flush;
  logic [2:0] occ_a;
  logic [2:0] occ_b;

  int checks;
  int errors;
  int delivered;
  logic [15:0] sb[$];

  logic        s_ur;
  logic        s_dv;
  logic [15:0] s_dd;
  logic [2:0]  s_occ;

  flow_bus_pipeline_if #(.DATA_WIDTH(16)) a_up ();
  flow_bus_pipeline_if #(.DATA_WIDTH(16)) a_dn ();
  flow_bus_pipeline_if #(.DATA_WIDTH(16)) b_up ();
  flow_bus_pipeline_if #(.DATA_WIDTH(16)) b_dn ();

  flow_bus_pipeline #(.DATA_WIDTH(16), .DEPTH(2), .USE_ENABLE(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable_a),
`ifdef FLOW_BUS_PIPELINE_FLUSH_EN
    .flush     (flush),
`endif
    .up        (a_up),
    .down      (a_dn),
    .occupancy (occ_a)
  );

  flow_bus_pipeline #(.DATA_WIDTH(16), .DEPTH(3), .USE_ENABLE(0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable_b),
`ifdef FLOW_BUS_PIPELINE_FLUSH_EN
    .flush     (flush),
`endif
    .up        (b_up),
    .down      (b_dn),
    .occupancy (occ_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [15:0] ud;
    logic        dr;
    logic        en;
    logic        e_ur;
    logic        e_dv;
    logic [15:0] e_dd;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle on the selected DUT (0 = dut_a, 1 = dut_b). Inputs are
  // driven now (just after a rising edge), outputs sampled on the falling
  // edge, and the task returns just after the next rising edge.
  task automatic cycle(input bit sel, input logic uv, input logic [15:0] d,
                       input logic dr, input logic en, input bit use_sb);
    logic [15:0] exp_word;
    if (!sel) begin
      a_up.valid = uv; a_up.data = d; a_dn.ready = dr; enable_a = en;
    end else begin
      b_up.valid = uv; b_up.data = d; b_dn.ready = dr;
    end
    @(negedge clk);
    s_ur  = sel ? b_up.ready : a_up.ready;
    s_dv  = sel ? b_dn.valid : a_dn.valid;
    s_dd  = sel ? b_dn.data  : a_dn.data;
    s_occ = sel ? occ_b      : occ_a;
    if (use_sb) begin
      check("occupancy_vs_scoreboard", 32'(s_occ), 32'(sb.size()));
      if (uv && s_ur) sb.push_back(d);
      if (s_dv && dr) begin
        check("delivery_has_pending_word", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_word = sb.pop_front();
          check("word_order", 32'(s_dd), 32'(exp_word));
        end
        delivered = delivered + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int guard;
    checks    = 0;
    errors    = 0;
    delivered = 0;
    flush     = 1'b0;
    enable_a  = 1'b1;
    enable_b  = 1'b1;
    a_up.valid = 1'b1; a_up.data = 16'h0; a_dn.ready = 1'b0;
    b_up.valid = 1'b1; b_up.data = 16'h0; b_dn.ready = 1'b0;

    tbl[0]  = '{1'b1, 16'h00A1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[1]  = '{1'b1, 16'h00A2, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd1};
    tbl[2]  = '{1'b1, 16'h00A3, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A1, 3'd2};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A2, 3'd2};
    tbl[4]  = '{1'b1, 16'h00A4, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A2, 3'd2};
    tbl[5]  = '{1'b1, 16'h00A5, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A2, 3'd3};
    tbl[6]  = '{1'b1, 16'h00A6, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A2, 3'd4};
    tbl[7]  = '{1'b1, 16'h00A6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd4};
    tbl[8]  = '{1'b1, 16'h00A6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd4};
    tbl[9]  = '{1'b1, 16'h00A6, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00A2, 3'd4};
    tbl[10] = '{1'b1, 16'h00A6, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00A3, 3'd3};
    tbl[11] = '{1'b1, 16'h00A6, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A4, 3'd2};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A5, 3'd2};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A6, 3'd1};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};

    // Reset held for three cycles with valid offered.
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_a_down_valid", 32'(a_dn.valid), 32'd0);
      check("reset_a_up_ready",   32'(a_up.ready), 32'd0);
      check("reset_a_occupancy",  32'(occ_a),      32'd0);
      check("reset_b_down_valid", 32'(b_dn.valid), 32'd0);
      check("reset_b_up_ready",   32'(b_up.ready), 32'd0);
      check("reset_b_occupancy",  32'(occ_b),      32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge_a", 32'(a_up.ready), 32'd0);
    check("ready_before_first_edge_b", 32'(b_up.ready), 32'd0);
    @(posedge clk);
    #1;
    a_up.valid = 1'b0;
    b_up.valid = 1'b0;
    @(negedge clk);
    check("ready_after_first_edge_a", 32'(a_up.ready), 32'd1);
    check("ready_after_first_edge_b", 32'(b_up.ready), 32'd1);
    check("no_word_taken_in_reset_a", 32'(occ_a), 32'd0);
    @(posedge clk);
    #1;

    // Directed vector table on dut_a.
    for (int k = 0; k < 15; k++) begin
      cycle(1'b0, tbl[k].uv, tbl[k].ud, tbl[k].dr, tbl[k].en, 1'b0);
      check($sformatf("vec%0d_up_ready", k),   32'(s_ur),  32'(tbl[k].e_ur));
      check($sformatf("vec%0d_down_valid", k), 32'(s_dv),  32'(tbl[k].e_dv));
      check($sformatf("vec%0d_occupancy", k),  32'(s_occ), 32'(tbl[k].e_occ));
      if (tbl[k].e_dv) check($sformatf("vec%0d_down_data", k), 32'(s_dd), 32'(tbl[k].e_dd));
    end

    // Streaming on dut_a: words 1..16 back to back, two-cycle latency.
    sb.delete();
    for (int c = 0; c < 19; c++) begin
      cycle(1'b0, 1'(c < 16), 16'(c + 1), 1'b1, 1'b1, 1'b1);
      if (c < 16) check("stream_up_ready", 32'(s_ur), 32'd1);
      check("stream_down_valid", 32'(s_dv), 32'((c >= 2) && (c <= 17)));
      if (c >= 2 && c <= 16) check("stream_occupancy", 32'(s_occ), 32'd2);
    end
    check("stream_drained", 32'(sb.size()), 32'd0);

    // Enable dropped for four cycles mid-stream on dut_a.
    sb.delete();
    n = 0;
    for (int c = 0; c < 16; c++) begin
      logic en_c;
      en_c = !(c >= 5 && c <= 8);
      cycle(1'b0, 1'b1, 16'h0200 + 16'(n), 1'b1, en_c, 1'b1);
      if (!en_c) begin
        check("stall_up_ready", 32'(s_ur), 32'd0);
        check("stall_down_valid", 32'(s_dv), 32'd0);
      end
      if (s_ur) n = n + 1;
    end
    for (int c = 0; c < 10 && sb.size() != 0; c++) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    check("stall_drained", 32'(sb.size()), 32'd0);

    // Full backpressure on dut_b (DEPTH=3).
    sb.delete();
    n = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, 1'b1, 16'h0100 + 16'(n), 1'b0, 1'b1, 1'b1);
      if (s_ur) n = n + 1;
    end
    check("bp_accepted", 32'(n), 32'd6);
    check("bp_up_ready", 32'(s_ur), 32'd0);
    check("bp_occupancy", 32'(s_occ), 32'd6);
    for (int c = 0; c < 12 && sb.size() != 0; c++) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    check("bp_drained", 32'(sb.size()), 32'd0);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    check("bp_idle_valid", 32'(s_dv), 32'd0);

    // Random valid/ready on dut_b with scoreboard.
    sb.delete();
    delivered = 0;
    guard = 0;
    while (delivered < 10000 && guard < 60000) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      guard = guard + 1;
    end
    check("random_words_delivered", 32'(delivered >= 10000), 32'd1);
    for (int c = 0; c < 20 && sb.size() != 0; c++) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    check("random_drained", 32'(sb.size()), 32'd0);

`ifdef FLOW_BUS_PIPELINE_FLUSH_EN
    // Flush with five words held in dut_b.
    sb.delete();
    n = 0;
    guard = 0;
    while (n < 5 && guard < 20) begin
      cycle(1'b1, 1'b1, 16'h0300 + 16'(n), 1'b0, 1'b1, 1'b1);
      if (s_ur) n = n + 1;
      guard = guard + 1;
    end
    check("flush_fill_count", 32'(n), 32'd5);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("flush_pre_occupancy", 32'(s_occ), 32'd5);
    flush = 1'b1;
    cycle(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
    check("flush_up_ready", 32'(s_ur), 32'd1);
    flush = 1'b0;
    sb.delete();
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    check("flush_post_occupancy", 32'(s_occ), 32'd0);
    check("flush_post_down_valid", 32'(s_dv), 32'd0);
    check("flush_post_up_ready", 32'(s_ur), 32'd1);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      check("flush_nothing_delivered", 32'(s_dv), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
